hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core, directly downstream of the D-stage use/new-time decoder. Each cycle it takes the decoded D-stage register descriptor (r_new/t_new, r_use1/2, t_use1/2) and carries the write descriptor down through internal E, M and W shadow registers, decrementing the remaining-latency field per stage. It compares the D-stage needs against those shadows and produces the stall/bubble control plus forwarding selects for the D, E and M stages.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all shadow registers
- d_r_new  in  5  destination register of D instruction (0 = none)
- d_t_new  in  2  cycles from D until result is produced
- d_r_use1  in  5  first source register (rs) of D instruction
- d_r_use2  in  5  second source register (rt) of D instruction
- d_t_use1  in  2  cycles from D until r_use1 is consumed
- d_t_use2  in  2  cycles from D until r_use2 is consumed
- stall  out  1  freeze PC and IF/ID register
- flush_e  out  1  load a bubble into ID/EX (equals stall)
- d_fwd_rs  out  2  D-stage rs source: 0 GRF, 1 E, 2 M, 3 W
- d_fwd_rt  out  2  D-stage rt source: same encoding
- e_fwd_rs  out  2  E-stage rs source: 0 ID/EX value, 1 M, 2 W
- e_fwd_rt  out  2  E-stage rt source: same encoding
- m_fwd_rt  out  1  M-stage store data: 0 EX/MEM value, 1 W

## Operation
- State: E record {r_new, t_new, r_use1, r_use2}, M record {r_new, t_new, r_use2}, W record {r_new, t_new}.
- Every rising edge:
  - E ← stall ? all-zero bubble : {d_r_new, sat_dec(d_t_new), d_r_use1, d_r_use2}.
  - M ← {E.r_new, sat_dec(E.t_new), E.r_use2}.
  - W ← {M.r_new, sat_dec(M.t_new)}.
  - sat_dec(x) = x==0 ? 0 : x-1 (2-bit, never wraps).
- Match(S, r): S.r_new != 0 and S.r_new == r. Register $0 never matches, never stalls, never forwards.
- Stall condition for source i (i = 1, 2):
  - d_r_use_i != 0 and (Match(E, d_r_use_i) and E.t_new > d_t_use_i, or Match(M, d_r_use_i) and M.t_new > d_t_use_i).
  - W never causes a stall.
- stall = stall condition for source 1 OR source 2; flush_e = stall.
- D forwarding: nearest match wins, priority E > M > W, else 0.
  - Select is produced even when the producer's t_new != 0. The stall rule then guarantees the value is either not needed yet or re-forwarded in a later stage.
- E forwarding: e_fwd_rs from E.r_use1, priority M(1) > W(2) > 0. e_fwd_rt likewise from E.r_use2.
- M forwarding: m_fwd_rt = Match(W, M.r_use2).
- No state machine beyond the three-deep shadow pipe. The block holds no data values, only register indices and latencies.

## Timing
- stall, flush_e and all fwd selects are combinational from D inputs and current shadow state, valid in the same cycle.
- Shadow registers update one cycle after D presentation. While stall=1 the upstream holds D inputs stable, and the same descriptor is re-evaluated next cycle.
- Reset (async assert, any time, including mid-stall): all shadow fields go to 0 immediately. The outputs then reduce to functions of the D inputs alone: stall=0, flush_e=0, all fwd selects 0. Deassertion is synchronised externally.
- A stall lasts at most 2 consecutive cycles (lw followed by a t_use=0 consumer). Each stall cycle shifts a bubble into E.
- Simultaneous E and M matches: E has priority for both the stall check and the D select.

## Test plan
- Reset mid-operation: with E.r_new=5, t_new=2, assert reset → E/M/W cleared within the same cycle; stall=0; all selects 0.
- lw $1 (t_new 3), then addu $2,$1,$3 (t_use1 1):
  - cycle 1: stall=1, flush_e=1;
  - cycle 2: stall=0;
  - cycle 3: addu in E with lw in W → e_fwd_rs=2.
- addu $1 (t_new 2), then beq $1,$4 (t_use 0):
  - cycle 1: stall=1;
  - cycle 2: addu in M with t_new 0 → stall=0, d_fwd_rs=2.
- lw $1, then sw $1,0($2) (t_use2 2): never stalls; when sw reaches M with lw in W → m_fwd_rt=1.
- ori $0,$0,5, then addu $2,$0,$0 → stall=0, d_fwd_rs=d_fwd_rt=0; later e_fwd_rs=e_fwd_rt=0.
- lw $1, then beq $1,$1: stall=1 for exactly two cycles; then d_fwd_rs=d_fwd_rt=3 (W), stall=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall, bubble and forwarding control for the five-stage pipeline.
// Shadows only register indices and remaining latencies; no data values.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_r_new,
  input  logic [1:0] d_t_new,
  input  logic [4:0] d_r_use1,
  input  logic [4:0] d_r_use2,
  input  logic [1:0] d_t_use1,
  input  logic [1:0] d_t_use2,
  output logic       stall,
  output logic       flush_e,
  output logic [1:0] d_fwd_rs,
  output logic [1:0] d_fwd_rt,
  output logic [1:0] e_fwd_rs,
  output logic [1:0] e_fwd_rt,
  output logic       m_fwd_rt
);

  typedef struct packed {
    logic [4:0] r_new;
    logic [1:0] t_new;
    logic [4:0] r_use1;
    logic [4:0] r_use2;
  } e_rec_t;

  typedef struct packed {
    logic [4:0] r_new;
    logic [1:0] t_new;
    logic [4:0] r_use2;
  } m_rec_t;

  // M.t_new is at most 1, so the W latency always saturates to 0
  // and only the destination index needs to be kept.
  typedef struct packed {
    logic [4:0] r_new;
  } w_rec_t;

  e_rec_t e_q, e_d;
  m_rec_t m_q, m_d;
  w_rec_t w_q, w_d;

  logic stall1, stall2;

  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  function automatic logic hit(
    input logic [4:0] dst,
    input logic [4:0] src
  );
    return (dst != 5'd0) && (dst == src);
  endfunction

  // The youngest producer decides; an older match is superseded.
  always_comb begin
    stall1 = 1'b0;
    if (hit(e_q.r_new, d_r_use1))
      stall1 = e_q.t_new > d_t_use1;
    else if (hit(m_q.r_new, d_r_use1))
      stall1 = m_q.t_new > d_t_use1;
  end

  always_comb begin
    stall2 = 1'b0;
    if (hit(e_q.r_new, d_r_use2))
      stall2 = e_q.t_new > d_t_use2;
    else if (hit(m_q.r_new, d_r_use2))
      stall2 = m_q.t_new > d_t_use2;
  end

  assign stall   = stall1 | stall2;
  assign flush_e = stall;

  always_comb begin
    d_fwd_rs = 2'd0;
    if (hit(e_q.r_new, d_r_use1))
      d_fwd_rs = 2'd1;
    else if (hit(m_q.r_new, d_r_use1))
      d_fwd_rs = 2'd2;
    else if (hit(w_q.r_new, d_r_use1))
      d_fwd_rs = 2'd3;
  end

  always_comb begin
    d_fwd_rt = 2'd0;
    if (hit(e_q.r_new, d_r_use2))
      d_fwd_rt = 2'd1;
    else if (hit(m_q.r_new, d_r_use2))
      d_fwd_rt = 2'd2;
    else if (hit(w_q.r_new, d_r_use2))
      d_fwd_rt = 2'd3;
  end

  always_comb begin
    e_fwd_rs = 2'd0;
    if (hit(m_q.r_new, e_q.r_use1))
      e_fwd_rs = 2'd1;
    else if (hit(w_q.r_new, e_q.r_use1))
      e_fwd_rs = 2'd2;
  end

  always_comb begin
    e_fwd_rt = 2'd0;
    if (hit(m_q.r_new, e_q.r_use2))
      e_fwd_rt = 2'd1;
    else if (hit(w_q.r_new, e_q.r_use2))
      e_fwd_rt = 2'd2;
  end

  assign m_fwd_rt = hit(w_q.r_new, m_q.r_use2);

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.r_new  = d_r_new;
      e_d.t_new  = sat_dec(d_t_new);
      e_d.r_use1 = d_r_use1;
      e_d.r_use2 = d_r_use2;
    end
    m_d.r_new  = e_q.r_new;
    m_d.t_new  = sat_dec(e_q.t_new);
    m_d.r_use2 = e_q.r_use2;
    w_d.r_new  = m_q.r_new;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus
// random descriptors against an instruction-level pipeline model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_r_new, d_r_use1, d_r_use2;
  logic [1:0] d_t_new, d_t_use1, d_t_use2;
  logic       stall, flush_e, m_fwd_rt;
  logic [1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;

  int total = 0;
  int bad   = 0;

  // Model: original descriptors of instructions in E(1), M(2), W(3).
  int p_rd[1:3];
  int p_tn[1:3];
  int p_rs[1:3];
  int p_rt[1:3];

  hazard_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .d_r_new  (d_r_new),
    .d_t_new  (d_t_new),
    .d_r_use1 (d_r_use1),
    .d_r_use2 (d_r_use2),
    .d_t_use1 (d_t_use1),
    .d_t_use2 (d_t_use2),
    .stall    (stall),
    .flush_e  (flush_e),
    .d_fwd_rs (d_fwd_rs),
    .d_fwd_rt (d_fwd_rt),
    .e_fwd_rs (e_fwd_rs),
    .e_fwd_rt (e_fwd_rt),
    .m_fwd_rt (m_fwd_rt)
  );

  always #5 clk = ~clk;

  logic [10:0] obs;
  assign obs = {stall, flush_e, d_fwd_rs, d_fwd_rt,
                e_fwd_rs, e_fwd_rt, m_fwd_rt};

  function automatic int rem(int k);
    return (p_tn[k] > k) ? p_tn[k] - k : 0;
  endfunction

  function automatic bit hit(int k, int r);
    return (r != 0) && (p_rd[k] == r);
  endfunction

  function automatic bit need_stall(int r, int tu);
    if (hit(1, r)) return rem(1) > tu;
    if (hit(2, r)) return rem(2) > tu;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return need_stall(int'(d_r_use1), int'(d_t_use1)) ||
           need_stall(int'(d_r_use2), int'(d_t_use2));
  endfunction

  function automatic int dsel(int r);
    if (hit(1, r)) return 1;
    if (hit(2, r)) return 2;
    if (hit(3, r)) return 3;
    return 0;
  endfunction

  function automatic int esel(int r);
    if (hit(2, r)) return 1;
    if (hit(3, r)) return 2;
    return 0;
  endfunction

  function automatic logic [10:0] expv();
    logic s, m;
    logic [1:0] a, b, c, d;
    s = m_stall();
    a = 2'(dsel(int'(d_r_use1)));
    b = 2'(dsel(int'(d_r_use2)));
    c = 2'(esel(p_rs[1]));
    d = 2'(esel(p_rt[1]));
    m = hit(3, p_rt[2]);
    return {s, s, a, b, c, d, m};
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= 3; k++) begin
      p_rd[k] = 0; p_tn[k] = 0; p_rs[k] = 0; p_rt[k] = 0;
    end
  endtask

  task automatic apply(input int rd, input int tn, input int rs,
                       input int rt, input int tu1, input int tu2);
    d_r_new  = 5'(rd);
    d_t_new  = 2'(tn);
    d_r_use1 = 5'(rs);
    d_r_use2 = 5'(rt);
    d_t_use1 = 2'(tu1);
    d_t_use2 = 2'(tu2);
    #1;
  endtask

  task automatic tick();
    bit s;
    s = m_stall();
    @(posedge clk);
    for (int k = 3; k >= 2; k--) begin
      p_rd[k] = p_rd[k-1]; p_tn[k] = p_tn[k-1];
      p_rs[k] = p_rs[k-1]; p_rt[k] = p_rt[k-1];
    end
    if (s) begin
      p_rd[1] = 0; p_tn[1] = 0; p_rs[1] = 0; p_rt[1] = 0;
    end else begin
      p_rd[1] = d_r_new;  p_tn[1] = d_t_new;
      p_rs[1] = d_r_use1; p_rt[1] = d_r_use2;
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    apply(0, 0, 3, 4, 0, 0);
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset_idle: got %b want %b", obs, 11'd0);
    end
    reset = 1'b0;
    tick();
    apply(5, 3, 0, 0, 0, 0);
    tick();
    apply(0, 0, 5, 0, 0, 0);
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_stall: got %b want 1", stall);
    end
    reset = 1'b1;
    model_clear();
    #1;
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset_async: got %b want %b", obs, 11'd0);
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", obs, 11'd0);
    end
    drain();
  endtask

  task automatic test_lw_use();
    apply(1, 3, 2, 0, 1, 3);
    tick();
    apply(2, 2, 1, 3, 1, 1);
    total++;
    if ({stall, flush_e} !== 2'b11) begin
      bad++;
      $display("FAIL lw_use_c1: got %b want 11", {stall, flush_e});
    end
    tick();
    total++;
    if ({stall, d_fwd_rs} !== 3'b0_10) begin
      bad++;
      $display("FAIL lw_use_c2: got %b want 010", {stall, d_fwd_rs});
    end
    tick();
    apply(0, 0, 0, 0, 0, 0);
    total++;
    if ({e_fwd_rs, e_fwd_rt} !== 4'b10_00) begin
      bad++;
      $display("FAIL lw_use_e: got %b want 1000", {e_fwd_rs, e_fwd_rt});
    end
    drain();
  endtask

  task automatic test_branch_fwd();
    apply(1, 2, 2, 3, 1, 1);
    tick();
    apply(0, 0, 1, 4, 0, 0);
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL branch_c1: got %b want 1", stall);
    end
    tick();
    total++;
    if ({stall, d_fwd_rs, d_fwd_rt} !== 5'b0_10_00) begin
      bad++;
      $display("FAIL branch_c2: got %b want 01000",
               {stall, d_fwd_rs, d_fwd_rt});
    end
    drain();
  endtask

  task automatic test_store_fwd();
    apply(1, 3, 2, 0, 1, 3);
    tick();
    apply(0, 0, 2, 1, 1, 2);
    total++;
    if ({stall, d_fwd_rt} !== 3'b0_01) begin
      bad++;
      $display("FAIL store_d: got %b want 001", {stall, d_fwd_rt});
    end
    tick();
    apply(0, 0, 0, 0, 0, 0);
    total++;
    if ({stall, e_fwd_rt} !== 3'b0_01) begin
      bad++;
      $display("FAIL store_e: got %b want 001", {stall, e_fwd_rt});
    end
    tick();
    total++;
    if (m_fwd_rt !== 1'b1) begin
      bad++;
      $display("FAIL store_m: got %b want 1", m_fwd_rt);
    end
    drain();
  endtask

  task automatic test_zero_reg();
    apply(0, 2, 0, 0, 1, 3);
    tick();
    apply(2, 2, 0, 0, 0, 0);
    total++;
    if ({stall, d_fwd_rs, d_fwd_rt} !== 5'd0) begin
      bad++;
      $display("FAIL zero_d: got %b want 00000",
               {stall, d_fwd_rs, d_fwd_rt});
    end
    tick();
    apply(0, 0, 0, 0, 0, 0);
    tick();
    total++;
    if ({e_fwd_rs, e_fwd_rt} !== 4'd0) begin
      bad++;
      $display("FAIL zero_e: got %b want 0000", {e_fwd_rs, e_fwd_rt});
    end
    drain();
  endtask

  task automatic test_double_stall();
    int n;
    apply(1, 3, 2, 0, 1, 3);
    tick();
    apply(0, 0, 1, 1, 0, 0);
    n = 0;
    while (stall === 1'b1 && n < 5) begin
      n++;
      tick();
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL dbl_len: got %0d want 2", n);
    end
    total++;
    if ({stall, d_fwd_rs, d_fwd_rt} !== 5'b0_11_11) begin
      bad++;
      $display("FAIL dbl_fwd: got %b want 01111",
               {stall, d_fwd_rs, d_fwd_rt});
    end
    drain();
  endtask

  task automatic test_random();
    bit held;
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held)
        apply($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      else
        #1;
      total++;
      if (obs !== expv()) begin
        bad++;
        $display("FAIL rand[%0d]: got %b want %b", i, obs, expv());
      end
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        model_clear();
        #1;
        total++;
        if (obs !== expv()) begin
          bad++;
          $display("FAIL rand_rst[%0d]: got %b want %b",
                   i, obs, expv());
        end
        reset = 1'b0;
      end
      held = m_stall();
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    model_clear();
    test_reset();
    test_lw_use();
    test_branch_fwd();
    test_store_fwd();
    test_zero_reg();
    test_double_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
